fa_if_adder: RTL and testbench

Registered full-adder block exposing the fa_if signal bundle (operands a, b, carry-in c; results s_out, c_out) as flat ports. It is a WIDTH-bit ripple-carry adder built from per-bit full-adder cells, each made of two half-adders. Results are captured in output registers with a valid flag. It sits behind any requester that needs single-cycle-latency add with carry, and serves as the clocked building block for wider datapaths.

---
 rtl/fa_if.sv | 36 +++
 rtl/fa_if_adder.sv | 98 +++++++++
 tb/tb_fa_if_adder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fa_if.sv
// ---------------------------------------------------------------------------
// fa_if
// Signal bundle for the registered ripple-carry adder.
//
//   in_valid  master->slave  operands on a/b/c are valid this cycle
//   a, b      master->slave  WIDTH-bit operands
//   c         master->slave  carry-in
//   s_out     slave->master  registered WIDTH-bit sum
//   c_out     slave->master  registered carry-out of the MSB
//   ovf       slave->master  registered signed overflow
//   out_valid slave->master  s_out/c_out/ovf hold the previous accepted result
//
// WIDTH must match the WIDTH of the adder the bundle is connected to (1..64).
// ---------------------------------------------------------------------------
interface fa_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] s_out;
  logic             c_out;
  logic             ovf;
  logic             out_valid;

  modport master (
    output in_valid, a, b, c,
    input  s_out, c_out, ovf, out_valid
  );

  modport slave (
    input  in_valid, a, b, c,
    output s_out, c_out, ovf, out_valid
  );
endinterface : fa_if

// File: rtl/fa_if_adder.sv
// ---------------------------------------------------------------------------
// fa_if_adder
// Registered WIDTH-bit ripple-carry adder. Each bit is a full-adder cell made
// of two half-adders; the carry ripples from bit 0 (seeded by bus.c) to the
// MSB. Sum, carry-out and signed overflow are captured in output registers
// with one cycle of latency; there is no combinational input-to-output path.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears all outputs immediately
//   bus    fa_if slave modport (in_valid, a, b, c in; s_out, c_out, ovf,
//          out_valid out)
//
// Parameter:
//   WIDTH  operand and sum width in bits, 1..64
// ---------------------------------------------------------------------------
module fa_if_adder #(
  parameter int WIDTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  fa_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Ripple-carry chain. carry[i] is the carry into cell i; carry[WIDTH] is
  // the carry out of the MSB.
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] p_bit;    // half-adder 1 sum (propagate)
  logic [WIDTH-1:0] g_bit;    // half-adder 1 carry (generate)
  logic [WIDTH-1:0] t_bit;    // half-adder 2 carry
  logic [WIDTH-1:0] sum_bit;  // half-adder 2 sum

  assign carry[0] = bus.c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa_cell
    // Half-adder 1: operands.
    assign p_bit[i]   = bus.a[i] ^ bus.b[i];
    assign g_bit[i]   = bus.a[i] & bus.b[i];
    // Half-adder 2: propagate with incoming carry.
    assign sum_bit[i] = p_bit[i] ^ carry[i];
    assign t_bit[i]   = p_bit[i] & carry[i];
    // Carry out of the cell: at most one of g/t can be set.
    assign carry[i+1] = g_bit[i] | t_bit[i];
  end

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  // For WIDTH=1 carry[0] is the external carry-in, giving c ^ c_out.
  logic ovf_comb;
  assign ovf_comb = carry[WIDTH-1] ^ carry[WIDTH];

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] s_out_q,     s_out_d;
  logic             c_out_q,     c_out_d;
  logic             ovf_q,       ovf_d;
  logic             out_valid_q, out_valid_d;

  // NOTE: every output of this block gets a default (hold) first, so no path
  // through it leaves a variable unassigned and no latch is inferred.
  always_comb begin
    s_out_d     = s_out_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    out_valid_d = bus.in_valid;
    // Operands are only looked at when in_valid is high, so X/unknown values
    // on an idle bus cannot reach the held result.
    if (bus.in_valid) begin
      s_out_d = sum_bit;
      c_out_d = carry[WIDTH];
      ovf_d   = ovf_comb;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its D input from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_out_q     <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_out_q     <= s_out_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s_out     = s_out_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule : fa_if_adder

// File: tb/tb_fa_if_adder.sv
// ---------------------------------------------------------------------------
// tb_fa_if_adder
// Directed bench for fa_if_adder: one WIDTH=1 instance and one WIDTH=8
// instance sharing clock and reset. Inputs change 1 ns after a rising edge
// and outputs are sampled 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_fa_if_adder;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  fa_if #(.WIDTH(1)) if1 ();
  fa_if #(.WIDTH(8)) if8 ();

  fa_if_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  fa_if_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic a, input logic b,
                        input logic c);
    if1.in_valid = v;
    if1.a        = a;
    if1.b        = b;
    if1.c        = c;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic c);
    if8.in_valid = v;
    if8.a        = a;
    if8.b        = b;
    if8.c        = c;
  endtask

  task automatic check8(input string tag, input logic [7:0] s,
                        input logic co, input logic ov, input logic vld);
    check({tag, ".s"},   if8.s_out,     s);
    check({tag, ".c"},   if8.c_out,     co);
    check({tag, ".ovf"}, if8.ovf,       ov);
    check({tag, ".vld"}, if8.out_valid, vld);
  endtask

  // Independent reference for the 8-bit path: plain integer add, with signed
  // overflow judged from operand and result signs.
  task automatic ref8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] s, output logic co, output logic ov);
    logic [8:0] full;
    full = {1'b0, a} + {1'b0, b} + {8'd0, c};
    s    = full[7:0];
    co   = full[8];
    ov   = (a[7] == b[7]) && (full[7] != a[7]);
  endtask

  // Watchdog: the bench never waits on anything but clock edges, but bound it.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ea, eb, es;
    logic       ec, eco, eov;
    logic [1:0] pop;

    rst_n = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);

    // ---- reset state, before any clock edge ----
    #2;
    check("rst1.s",   if1.s_out,     1'b0);
    check("rst1.c",   if1.c_out,     1'b0);
    check("rst1.ovf", if1.ovf,       1'b0);
    check("rst1.vld", if1.out_valid, 1'b0);
    check8("rst8", 8'h00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- WIDTH=1 truth vectors, back-to-back ----
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("tv0.s", if1.s_out, 1'b1); check("tv0.c", if1.c_out, 1'b0);
    check("tv0.vld", if1.out_valid, 1'b1);
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    check("tv1.s", if1.s_out, 1'b1); check("tv1.c", if1.c_out, 1'b1);
    check("tv1.vld", if1.out_valid, 1'b1);
    drive1(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("tv2.s", if1.s_out, 1'b0); check("tv2.c", if1.c_out, 1'b1);
    check("tv2.vld", if1.out_valid, 1'b1);

    // ---- WIDTH=1 exhaustive ----
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      drive1(1'b1, v[2], v[1], v[0]);
      step();
      pop = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      check($sformatf("ex%0d.sum", i), {if1.c_out, if1.s_out}, pop);
      check($sformatf("ex%0d.ovf", i), if1.ovf, v[0] ^ pop[1]);
      check($sformatf("ex%0d.vld", i), if1.out_valid, 1'b1);
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);

    // ---- WIDTH=8 carry ripple through all bits ----
    drive8(1'b1, 8'hFF, 8'h00, 1'b1);
    step();
    check8("rip0", 8'h00, 1'b1, 1'b0, 1'b1);
    drive8(1'b1, 8'h7F, 8'h01, 1'b0);
    step();
    check8("rip1", 8'h80, 1'b0, 1'b1, 1'b1);
    drive8(1'b1, 8'h80, 8'h80, 1'b0);
    step();
    check8("rip2", 8'h00, 1'b1, 1'b1, 1'b1);

    // ---- hold behaviour, unknown operands while idle ----
    drive8(1'b1, 8'h12, 8'h34, 1'b0);
    step();
    check8("hold0", 8'h46, 1'b0, 1'b0, 1'b1);
    drive8(1'b0, 8'hFF, 8'hFF, 1'b1);
    if8.a = 'x;
    if8.c = 1'bx;
    step();
    check8("hold1", 8'h46, 1'b0, 1'b0, 1'b0);
    step();
    check8("hold2", 8'h46, 1'b0, 1'b0, 1'b0);

    // ---- random stream with mid-stream reset pulse ----
    for (int n = 0; n < 24; n++) begin
      ea = 8'($urandom);
      eb = 8'($urandom);
      ec = 1'($urandom);
      drive8(1'b1, ea, eb, ec);
      ref8(ea, eb, ec, es, eco, eov);
      step();
      check8($sformatf("str%0d", n), es, eco, eov, 1'b1);
      if (n == 11) begin
        // Pulse reset between edges: outputs clear at once, stay clear.
        #2;
        rst_n = 1'b0;
        #1;
        check8("mrst.now", 8'h00, 1'b0, 1'b0, 1'b0);
        check("mrst1.vld", if1.out_valid, 1'b0);
        #4;
        rst_n = 1'b1;
        #1;
        check8("mrst.rel", 8'h00, 1'b0, 1'b0, 1'b0);
      end
    end

    // Idle once more: valid drops, result held.
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    step();
    check8("tail", es, eco, eov, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fa_if_adder
